// File: rtl/config_write_fifo_mc_pkg.sv
// Shared constants, helpers and types for the multi-channel config write FIFO.
package config_write_fifo_mc_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned MaxCntW = 32;

  // The control register sits at the first address past the last channel, so its offset
  // from BASE_ADDR (CTRL_OFFSET) equals the channel count.
  function automatic int unsigned ctrl_offset(input int unsigned n_channels);
    return n_channels;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  typedef struct packed {
    logic               overflow;
    logic [MaxCntW-1:0] drop_count;
  } ch_status_t;

endpackage

// File: rtl/config_write_fifo_mc_if.sv
// Config write bus: one write per cycle, no backpressure.
interface config_write_fifo_mc_if #(
  parameter int unsigned CFG_W = 64
);
  import config_write_fifo_mc_pkg::*;

  logic             valid;
  logic [AddrW-1:0] addr;
  logic [CFG_W-1:0] data;

  modport m (output valid, addr, data);
  modport s (input valid, addr, data);

endinterface

// File: rtl/FIFO.sv
// First-word-fall-through FIFO; accepts a write while full if a read happens the same cycle.
module FIFO #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FullLevel = DEPTH[AW:0];
  localparam logic [AW:0]   LvlOne    = 1;
  localparam logic [AW-1:0] PtrOne    = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == FullLevel);
  assign o_level   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  assign do_rd = i_rd_en & ~o_empty;
  assign do_wr = i_wr_en & (~o_full | do_rd);

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + LvlOne;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - LvlOne;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule

// File: rtl/config_beat_assembler.sv
// One channel: gathers CFG_W beats into a DATA_W word, stages it for the FIFO and tracks drops.
module config_beat_assembler
  import config_write_fifo_mc_pkg::*;
#(
  parameter int unsigned CFG_W  = 64,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [CFG_W-1:0]  wr_data_i,
  input  logic              flush_i,
  input  logic              clear_i,
  input  logic              fifo_full_i,
  input  logic              fifo_pop_i,
  output logic              push_o,
  output logic [DATA_W-1:0] push_data_o,
  output ch_status_t        status_o
);

  localparam int unsigned      Beats    = DATA_W / CFG_W;
  localparam int unsigned      BeatW    = beat_cnt_w(Beats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [BeatW-1:0] BeatOne  = 1;
  localparam logic [CNT_W-1:0] CntOne   = 1;

  logic [BeatW-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] shadow_q, shadow_d, word;
  logic              push_q, push_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              drop;

  always_comb begin
    word = shadow_q;
    word[32'(beat_q) * CFG_W +: CFG_W] = wr_data_i;

    beat_d      = beat_q;
    shadow_d    = shadow_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (flush_i) begin
      beat_d   = '0;
      shadow_d = '0;
    end else if (wr_i) begin
      if (beat_q == LastBeat) begin
        beat_d      = '0;
        shadow_d    = '0;
        push_d      = 1'b1;
        push_data_d = word;
      end else begin
        beat_d   = beat_q + BeatOne;
        shadow_d = word;
      end
    end
  end

  // Full is judged against the pre-pop level, so a same-cycle pop makes room.
  assign drop        = push_q & fifo_full_i & ~fifo_pop_i;
  assign push_o      = push_q & ~drop;
  assign push_data_o = push_data_q;

  // A drop in the same cycle as a clear wins and counts as the first drop.
  always_comb begin
    overflow_d = overflow_q & ~clear_i;
    drop_cnt_d = clear_i ? '0 : drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_cnt_d)) begin
        drop_cnt_d = drop_cnt_d + CntOne;
      end
    end
  end

  always_comb begin
    status_o                        = '0;
    status_o.overflow               = overflow_q;
    status_o.drop_count[CNT_W-1:0]  = drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= '0;
      shadow_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      beat_q      <= beat_d;
      shadow_q    <= shadow_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: rtl/config_write_fifo_mc.sv
// Multi-channel config write FIFO: decodes N_CHANNELS data addresses plus one control address
// and buffers assembled words per channel.
module config_write_fifo_mc
  import config_write_fifo_mc_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CFG_W      = 64,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  config_write_fifo_mc_if.s                       write_config,
  output logic [N_CHANNELS-1:0][DATA_W-1:0]       o_data,
  output logic [N_CHANNELS-1:0]                   o_valid,
  input  logic [N_CHANNELS-1:0]                   o_ready,
  output logic [N_CHANNELS-1:0]                   o_overflow,
  output logic [N_CHANNELS-1:0][CNT_W-1:0]        o_drop_count,
  output logic [N_CHANNELS-1:0][$clog2(DEPTH):0]  o_level
);

  localparam int unsigned CTRL_OFFSET = ctrl_offset(N_CHANNELS);

  logic ctrl_wr;

  assign ctrl_wr = write_config.valid &&
                   (write_config.addr == AddrW'(BASE_ADDR + CTRL_OFFSET));

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic              sel, clear, flush;
    logic              push, full, empty, pop;
    logic [DATA_W-1:0] push_data, head;
    ch_status_t        status;
    logic              unused_status;

    assign sel   = write_config.valid && (write_config.addr == AddrW'(BASE_ADDR + c));
    // Low N bits of a control write clear status, the next N bits flush partial words.
    assign clear = ctrl_wr & write_config.data[c];
    assign flush = ctrl_wr & write_config.data[N_CHANNELS + c];
    assign pop   = ~empty & o_ready[c];

    config_beat_assembler #(
      .CFG_W  (CFG_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_asm (
      .clk         (clk),
      .rst         (rst),
      .wr_i        (sel),
      .wr_data_i   (write_config.data),
      .flush_i     (flush),
      .clear_i     (clear),
      .fifo_full_i (full),
      .fifo_pop_i  (pop),
      .push_o      (push),
      .push_data_o (push_data),
      .status_o    (status)
    );

    FIFO #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
    ) u_fifo (
      .i_clk     (clk),
      .i_rst_n   (~rst),
      .i_wr_en   (push),
      .i_wr_data (push_data),
      .i_rd_en   (pop),
      .o_rd_data (head),
      .o_full    (full),
      .o_empty   (empty),
      .o_level   (o_level[c])
    );

    // Storage is not reset, so the head is masked until a word is actually present.
    assign o_valid[c]      = ~empty;
    assign o_data[c]       = empty ? '0 : head;
    assign o_overflow[c]   = status.overflow;
    assign o_drop_count[c] = status.drop_count[CNT_W-1:0];
    assign unused_status   = ^status.drop_count;
  end

endmodule

// File: tb/tb_config_write_fifo_mc.sv
// Directed bench for config_write_fifo_mc with two beats per word.
module tb_config_write_fifo_mc;

  localparam int unsigned Base  = 32'h40;
  localparam int unsigned NCh   = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned CfgW  = 64;
  localparam int unsigned DataW = 128;
  localparam int unsigned CntW  = 16;
  localparam int unsigned LvlW  = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NCh-1:0][DataW-1:0] o_data;
  logic [NCh-1:0]            o_valid;
  logic [NCh-1:0]            o_ready;
  logic [NCh-1:0]            o_overflow;
  logic [NCh-1:0][CntW-1:0]  o_drop_count;
  logic [NCh-1:0][LvlW-1:0]  o_level;

  int total = 0;
  int bad   = 0;

  config_write_fifo_mc_if #(.CFG_W(CfgW)) cfg_bus ();

  config_write_fifo_mc #(
    .BASE_ADDR  (Base),
    .N_CHANNELS (NCh),
    .DEPTH      (Depth),
    .CFG_W      (CfgW),
    .DATA_W     (DataW),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_config (cfg_bus),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count),
    .o_level      (o_level)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [63:0] data);
    cfg_bus.valid = 1'b1;
    cfg_bus.addr  = addr;
    cfg_bus.data  = data;
    @(negedge clk);
    cfg_bus.valid = 1'b0;
  endtask

  task automatic push_word(input int ch, input logic [63:0] hi, input logic [63:0] lo);
    cfg_write(32'(Base + ch), lo);
    cfg_write(32'(Base + ch), hi);
  endtask

  task automatic pop_one(input int ch);
    o_ready[ch] = 1'b1;
    @(negedge clk);
    o_ready[ch] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    o_ready = '0;
    cfg_bus.valid = 1'b0;
    cfg_bus.addr  = '0;
    cfg_bus.data  = '0;
    idle(2);
    total++; if (o_valid !== '0) begin bad++; $display("FAIL reset_valid got=%h want=0", o_valid); end
    total++; if (o_overflow !== '0) begin bad++; $display("FAIL reset_ovf got=%h want=0", o_overflow); end
    total++; if (o_drop_count !== '0) begin bad++; $display("FAIL reset_drop got=%h want=0", o_drop_count); end
    total++; if (o_level !== '0) begin bad++; $display("FAIL reset_level got=%h want=0", o_level); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", o_data); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single_word;
    push_word(1, 64'h2222, 64'h1111);
    total++; if (o_valid !== 4'b0000) begin bad++; $display("FAIL single_early got=%b want=0000", o_valid); end
    idle(1);
    total++; if (o_valid !== 4'b0010) begin bad++; $display("FAIL single_valid got=%b want=0010", o_valid); end
    total++; if (o_data[1] !== {64'h2222, 64'h1111}) begin bad++; $display("FAIL single_data got=%h want=%h", o_data[1], {64'h2222, 64'h1111}); end
    total++; if (o_level[1] !== 5'd1) begin bad++; $display("FAIL single_level got=%0d want=1", o_level[1]); end
    pop_one(1);
    total++; if (o_valid !== 4'b0000 || o_level[1] !== 5'd0) begin bad++; $display("FAIL single_pop got=%b/%0d want=0000/0", o_valid, o_level[1]); end
  endtask

  task automatic test_decode;
    cfg_write(32'(Base + 5), 64'hAA);
    cfg_write(32'(Base + 5), 64'hBB);
    cfg_write(32'(Base - 1), 64'hCC);
    cfg_write(32'(Base - 1), 64'hDD);
    cfg_bus.addr = Base;
    cfg_bus.data = 64'hEE;
    idle(2);
    idle(2);
    total++; if (o_valid !== '0 || o_level !== '0) begin bad++; $display("FAIL decode_ignored got=%b/%h want=0/0", o_valid, o_level); end
    push_word(0, 64'h0B0B, 64'h0A0A);
    idle(1);
    total++; if (o_data[0] !== {64'h0B0B, 64'h0A0A}) begin bad++; $display("FAIL decode_clean got=%h want=%h", o_data[0], {64'h0B0B, 64'h0A0A}); end
    pop_one(0);
  endtask

  task automatic test_overflow;
    logic [DataW-1:0] exp;
    o_ready = '0;
    for (int i = 0; i < Depth + 3; i++) push_word(0, 64'h1000 + 64'(i), 64'h2000 + 64'(i));
    idle(1);
    total++; if (o_level[0] !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d want=16", o_level[0]); end
    total++; if (o_overflow !== 4'b0001) begin bad++; $display("FAIL ovf_flag got=%b want=0001", o_overflow); end
    total++; if (o_drop_count[0] !== 16'd3) begin bad++; $display("FAIL ovf_count got=%0d want=3", o_drop_count[0]); end
    idle(2);
    total++; if (o_data[0] !== {64'h1000, 64'h2000}) begin bad++; $display("FAIL ovf_hold got=%h want=%h", o_data[0], {64'h1000, 64'h2000}); end
    for (int i = 0; i < Depth; i++) begin
      exp = {64'h1000 + 64'(i), 64'h2000 + 64'(i)};
      total++; if (o_valid[0] !== 1'b1 || o_data[0] !== exp) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h want=1/%h", i, o_valid[0], o_data[0], exp); end
      pop_one(0);
    end
    total++; if (o_valid[0] !== 1'b0 || o_level[0] !== 5'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d want=0/0", o_valid[0], o_level[0]); end
    total++; if (o_overflow[0] !== 1'b1 || o_drop_count[0] !== 16'd3) begin bad++; $display("FAIL ovf_sticky got=%b/%0d want=1/3", o_overflow[0], o_drop_count[0]); end
    cfg_write(32'(Base + NCh), 64'h1);
    total++; if (o_overflow[0] !== 1'b0 || o_drop_count[0] !== 16'd0) begin bad++; $display("FAIL ovf_clear got=%b/%0d want=0/0", o_overflow[0], o_drop_count[0]); end
  endtask

  task automatic test_clear_collision;
    for (int i = 0; i < Depth; i++) push_word(0, 64'h3000 + 64'(i), 64'h4000 + 64'(i));
    idle(1);
    total++; if (o_level[0] !== 5'd16 || o_overflow[0] !== 1'b0) begin bad++; $display("FAIL coll_full got=%0d/%b want=16/0", o_level[0], o_overflow[0]); end
    push_word(0, 64'hDEAD, 64'hBEEF);
    cfg_write(32'(Base + NCh), 64'h1);
    total++; if (o_overflow[0] !== 1'b1 || o_drop_count[0] !== 16'd1) begin bad++; $display("FAIL coll_drop_wins got=%b/%0d want=1/1", o_overflow[0], o_drop_count[0]); end
    cfg_write(32'(Base + NCh), 64'h1);
    total++; if (o_overflow[0] !== 1'b0 || o_drop_count[0] !== 16'd0) begin bad++; $display("FAIL coll_clear got=%b/%0d want=0/0", o_overflow[0], o_drop_count[0]); end
    total++; if (o_level[0] !== 5'd16) begin bad++; $display("FAIL coll_level got=%0d want=16", o_level[0]); end
  endtask

  task automatic test_full_pop;
    logic [DataW-1:0] exp;
    push_word(0, 64'h5555, 64'h6666);
    pop_one(0);
    total++; if (o_overflow[0] !== 1'b0 || o_drop_count[0] !== 16'd0) begin bad++; $display("FAIL fullpop_nodrop got=%b/%0d want=0/0", o_overflow[0], o_drop_count[0]); end
    total++; if (o_level[0] !== 5'd16) begin bad++; $display("FAIL fullpop_level got=%0d want=16", o_level[0]); end
    for (int i = 0; i < Depth; i++) begin
      exp = (i < Depth - 1) ? {64'h3001 + 64'(i), 64'h4001 + 64'(i)} : {64'h5555, 64'h6666};
      total++; if (o_data[0] !== exp) begin bad++; $display("FAIL fullpop_drain%0d got=%h want=%h", i, o_data[0], exp); end
      pop_one(0);
    end
    total++; if (o_level[0] !== 5'd0) begin bad++; $display("FAIL fullpop_empty got=%0d want=0", o_level[0]); end
  endtask

  task automatic test_flush;
    cfg_write(32'(Base + 2), 64'hBAD0);
    cfg_write(32'(Base + NCh), 64'h1 << (NCh + 2));
    push_word(2, 64'hBBBB, 64'hAAAA);
    idle(1);
    total++; if (o_valid !== 4'b0100 || o_level[2] !== 5'd1) begin bad++; $display("FAIL flush_valid got=%b/%0d want=0100/1", o_valid, o_level[2]); end
    total++; if (o_data[2] !== {64'hBBBB, 64'hAAAA}) begin bad++; $display("FAIL flush_data got=%h want=%h", o_data[2], {64'hBBBB, 64'hAAAA}); end
    pop_one(2);
    push_word(2, 64'hC2, 64'hC1);
    cfg_write(32'(Base + NCh), 64'h1 << (NCh + 2));
    total++; if (o_data[2] !== {64'hC2, 64'hC1}) begin bad++; $display("FAIL flush_keeps_push got=%h want=%h", o_data[2], {64'hC2, 64'hC1}); end
    pop_one(2);
  endtask

  task automatic test_reset_mid;
    cfg_write(32'(Base + 3), 64'h0BAD);
    rst = 1'b1;
    #1;
    total++; if (o_valid !== '0 || o_level !== '0) begin bad++; $display("FAIL rstmid_beat got=%b/%h want=0/0", o_valid, o_level); end
    @(negedge clk);
    rst = 1'b0;
    push_word(3, 64'hD0D0, 64'hC0C0);
    idle(1);
    total++; if (o_data[3] !== {64'hD0D0, 64'hC0C0}) begin bad++; $display("FAIL rstmid_clean got=%h want=%h", o_data[3], {64'hD0D0, 64'hC0C0}); end
    rst = 1'b1;
    #1;
    total++; if (o_valid !== '0 || o_level !== '0 || o_data !== '0) begin bad++; $display("FAIL rstmid_fifo got=%b/%h want=0/0", o_valid, o_level); end
    @(negedge clk);
    rst = 1'b0;
    push_word(1, 64'hF2, 64'hF1);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    total++; if (o_valid !== '0 || o_level !== '0) begin bad++; $display("FAIL rstmid_push got=%b/%h want=0/0", o_valid, o_level); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_decode();
    test_overflow();
    test_clear_collision();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
